program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  UART-side program loader for the accumulator CPU: receives a framed instruction stream
//  from the UART receiver, assembles 16-bit instruction words (opcode[15:11], operand[10:0]).
//  Writes them sequentially into program memory and holds the CPU halted until loading ends.
//  Sends a one-byte acknowledge (word count) through the UART transmitter, then releases the CPU.
// PARAMETERS
//  DATA_W     16     instruction word width; must be 16 (two bytes, high byte first)
//  ADDR_W     11     program memory address width
//  SYNC_BYTE  8'hA5  frame start byte
//  OPC_MAX    5'd7   highest legal opcode (HLT..SUBI); larger opcodes are flagged
// PORTS
//  clk           in   1       system clock
//  reset         in   1       synchronous, active-high reset
//  rx_data       in   8       byte from UART receiver, valid when rx_done_tick=1
//  rx_done_tick  in   1       one-cycle strobe: new byte on rx_data
//  pm_we         out  1       program memory write enable, one-cycle pulse per word
//  pm_addr       out  ADDR_W  program memory write address
//  pm_data       out  DATA_W  program memory write data
//  tx_start      out  1       one-cycle pulse to UART transmitter
//  tx_data       out  8       acknowledge byte, valid while tx_start=1
//  cpu_run       out  1       1 = CPU may execute (PC/decoder enabled); 0 = CPU held
//  loading       out  1       1 while a frame is in progress (COUNT..WRITE)
//  bad_op        out  1       sticky: a loaded word had opcode > OPC_MAX
//  err_count     out  1       sticky: frame received with count byte = 0
// BEHAVIOUR
//  Reset: state=IDLE; pm_we=0, pm_addr=0, pm_data=0, tx_start=0, tx_data=0, cpu_run=0,
//   loading=0, bad_op=0, err_count=0. Reset mid-frame aborts; no further pm_we.
//  Frame: SYNC_BYTE, N (1..255), then 2N bytes, each word high byte then low byte.
//  FSM (advances only on rx_done_tick unless noted):
//   IDLE : byte==SYNC_BYTE -> COUNT, clear bad_op/err_count, cpu_run<=0; other bytes ignored.
//   COUNT: N==0 -> err_count<=1, IDLE; else latch N, word index<=0 -> HIGH.
//   HIGH : latch byte as word[15:8] -> LOW.
//   LOW  : word[7:0]<=byte -> WRITE.
//   WRITE: (unconditional, 1 cycle) pm_we=1, pm_addr=index, pm_data=word;
//          word[15:11]>OPC_MAX -> bad_op<=1 (word still written).
//          index==N-1 -> DONE; else index+1 -> HIGH.
//   DONE : (entered once) tx_start=1 one cycle, tx_data=N; next cycle cpu_run<=1, -> IDLE.
//  Latency: pm_we asserted exactly 1 cycle after the low byte's rx_done_tick;
//   tx_start 1 cycle after last pm_we; cpu_run rises 1 cycle after tx_start.
//  rx_done_tick arriving during WRITE/DONE is dropped (UART byte time >> 2 cycles).
//  After completion, cpu_run stays 1 until reset or a new SYNC_BYTE (drops the cycle after
//   that byte, so a reload always halts the CPU first). Other bytes while running ignored.
//  Address: pm_addr zero-extends the 8-bit index to ADDR_W; index never wraps (N<=255).
//  loading=1 in COUNT, HIGH, LOW, WRITE, DONE; 0 in IDLE.
//  pm_addr/pm_data hold last written value when pm_we=0.
// TESTING
//  Reset, then bytes A5,02,18,05,28,03 -> pm_we@0=0x1805, pm_we@1=0x2803; tx_data=0x02; cpu_run=1.
//  Bytes 00,FF,A5 then 01,08,10 -> first two ignored; single write addr 0 data 0x0810; ack 0x01.
//  A5,00 -> err_count=1, no pm_we, no tx_start, cpu_run stays 0; next A5 clears err_count.
//  A5,01,F8,00 -> write 0xF800 at 0, bad_op=1, cpu_run=1; new A5 clears bad_op, cpu_run->0.
//  A5,03,then 3 bytes, reset asserted -> no 2nd pm_we, all outputs at reset values next cycle.
//  A5,FF + 510 bytes -> 255 writes, addr 0..254 in order, tx_data=0xFF, no extra pm_we.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream and program-memory bundle between the UART side, the loader
// and the CPU's program memory / run control.
interface program_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
);
  logic [7:0]        rx_data;
  logic              rx_done_tick;
  logic              pm_we;
  logic [ADDR_W-1:0] pm_addr;
  logic [DATA_W-1:0] pm_data;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              cpu_run;
  logic              loading;
  logic              bad_op;
  logic              err_count;

  // Loader side: consumes received bytes, drives memory, transmitter and CPU control.
  modport slave (
    input  rx_data, rx_done_tick,
    output pm_we, pm_addr, pm_data, tx_start, tx_data,
    output cpu_run, loading, bad_op, err_count
  );

  // Environment side: supplies received bytes, observes everything else.
  modport master (
    output rx_data, rx_done_tick,
    input  pm_we, pm_addr, pm_data, tx_start, tx_data,
    input  cpu_run, loading, bad_op, err_count
  );
endinterface

// File: rtl/program_loader.sv
// Program loader for the accumulator CPU. Parses a framed byte stream
// (sync byte, word count, then high/low byte pairs), writes each assembled
// word into program memory, acknowledges with the word count through the
// UART transmitter and only then lets the CPU run.
module program_loader #(
  parameter int          DATA_W    = 16,
  parameter int          ADDR_W    = 11,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [4:0]  OPC_MAX   = 5'd7
) (
  input  logic          clk,
  input  logic          reset,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    HIGH,
    LOW,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  state_t            stateNext;

  logic [7:0]        wordCount;
  logic [7:0]        wordIdx;
  logic [7:0]        highByte;
  logic [ADDR_W-1:0] pmAddr;
  logic [DATA_W-1:0] pmData;
  logic [7:0]        txData;
  logic              cpuRun;
  logic              badOp;
  logic              errCount;

  logic              rxTick;
  logic              startFrame;
  logic              zeroCount;
  logic              takeCount;
  logic              takeHigh;
  logic              takeLow;
  logic              lastWord;
  logic [4:0]        opcode;

  assign rxTick   = bus.rx_done_tick;
  assign lastWord = (wordIdx == (wordCount - 8'd1));
  assign opcode   = pmData[DATA_W-1 -: 5];

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and per-byte strobes; WRITE and DONE ignore incoming bytes.
  always_comb begin
    stateNext  = state;
    startFrame = 1'b0;
    zeroCount  = 1'b0;
    takeCount  = 1'b0;
    takeHigh   = 1'b0;
    takeLow    = 1'b0;
    case (state)
      IDLE: begin
        if (rxTick && (bus.rx_data == SYNC_BYTE)) begin
          startFrame = 1'b1;
          stateNext  = COUNT;
        end
      end
      COUNT: begin
        if (rxTick) begin
          if (bus.rx_data == 8'd0) begin
            zeroCount = 1'b1;
            stateNext = IDLE;
          end else begin
            takeCount = 1'b1;
            stateNext = HIGH;
          end
        end
      end
      HIGH: begin
        if (rxTick) begin
          takeHigh  = 1'b1;
          stateNext = LOW;
        end
      end
      LOW: begin
        if (rxTick) begin
          takeLow   = 1'b1;
          stateNext = WRITE;
        end
      end
      WRITE: begin
        stateNext = lastWord ? DONE : HIGH;
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Frame bookkeeping, memory write port, acknowledge byte and CPU run/flag control.
  always_ff @(posedge clk) begin
    if (reset) begin
      wordCount <= 8'd0;
      wordIdx   <= 8'd0;
      pmAddr    <= '0;
      pmData    <= '0;
      txData    <= 8'd0;
      cpuRun    <= 1'b0;
      badOp     <= 1'b0;
      errCount  <= 1'b0;
    end else begin
      if (startFrame) begin
        badOp    <= 1'b0;
        errCount <= 1'b0;
        cpuRun   <= 1'b0;
      end
      if (zeroCount) begin
        errCount <= 1'b1;
      end
      if (takeCount) begin
        wordCount <= bus.rx_data;
        wordIdx   <= 8'd0;
      end
      if (takeLow) begin
        pmAddr <= ADDR_W'(wordIdx);
        pmData <= {highByte, bus.rx_data};
      end
      if (state == WRITE) begin
        if (opcode > OPC_MAX) begin
          badOp <= 1'b1;
        end
        if (lastWord) begin
          txData <= wordCount;
        end else begin
          wordIdx <= wordIdx + 8'd1;
        end
      end
      if (state == DONE) begin
        cpuRun <= 1'b1;
      end
    end
  end

  // High byte of the word being assembled; only meaningful between HIGH and WRITE.
  always_ff @(posedge clk) begin
    if (takeHigh) begin
      highByte <= bus.rx_data;
    end
  end

  assign bus.pm_we     = (state == WRITE);
  assign bus.tx_start  = (state == DONE);
  assign bus.loading   = (state != IDLE);
  assign bus.pm_addr   = pmAddr;
  assign bus.pm_data   = pmData;
  assign bus.tx_data   = txData;
  assign bus.cpu_run   = cpuRun;
  assign bus.bad_op    = badOp;
  assign bus.err_count = errCount;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of complete frames with expected results,
// hand-written multi-cycle sequences, and random frames checked against a
// queue-based frame model.
module tb_program_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  program_loader_if #(.DATA_W(16), .ADDR_W(11)) bus ();

  program_loader #(
    .DATA_W(16), .ADDR_W(11), .SYNC_BYTE(8'hA5), .OPC_MAX(5'd7)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int wrCount = 0;

  // Frame model state
  bit          mInFrame = 1'b0;
  logic [7:0]  mFrame[$];
  logic        expBad = 1'b0;
  logic        expErr = 1'b0;
  logic        expRun = 1'b0;
  logic [26:0] expWr[$];
  logic [7:0]  expAck[$];

  typedef struct {
    int          n;
    logic [63:0] bytes;
    int          expWrites;
    logic [15:0] expData;
    logic        expBadV;
    logic        expErrV;
    logic        expRunV;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: collect bytes after a sync byte; a word completes on every second
  // payload byte, the frame ends after 2N payload bytes.
  task automatic modelByte(input logic [7:0] b, output bit wordDone, output bit lastW);
    int i;
    logic [15:0] w;
    wordDone = 1'b0;
    lastW    = 1'b0;
    if (!mInFrame) begin
      if (b == 8'hA5) begin
        mInFrame = 1'b1;
        mFrame.delete();
        expBad = 1'b0;
        expErr = 1'b0;
        expRun = 1'b0;
      end
    end else begin
      mFrame.push_back(b);
      if (mFrame.size() == 1 && b == 8'h00) begin
        expErr   = 1'b1;
        mInFrame = 1'b0;
      end else if (mFrame.size() >= 3 && (mFrame.size() % 2) == 1) begin
        i = (mFrame.size() - 3) / 2;
        w = {mFrame[mFrame.size() - 2], b};
        expWr.push_back({11'(i), w});
        if (w[15:11] > 5'd7) expBad = 1'b1;
        wordDone = 1'b1;
        if (i == int'(mFrame[0]) - 1) begin
          lastW = 1'b1;
          expAck.push_back(mFrame[0]);
          expRun   = 1'b1;
          mInFrame = 1'b0;
        end
      end
    end
  endtask

  task automatic checkFlags();
    check("cpu_run", bus.cpu_run, expRun);
    check("loading", bus.loading, mInFrame);
    check("bad_op", bus.bad_op, expBad);
    check("err_count", bus.err_count, expErr);
  endtask

  task automatic sendByte(input logic [7:0] b);
    bit wd, lw;
    modelByte(b, wd, lw);
    @(negedge clk);
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    check("pm_we_latency", bus.pm_we, wd);
    @(negedge clk);
    check("tx_start_latency", bus.tx_start, lw);
    @(negedge clk);
    checkFlags();
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    bus.rx_done_tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mInFrame = 1'b0;
    mFrame.delete();
    expBad = 1'b0;
    expErr = 1'b0;
    expRun = 1'b0;
    expWr.delete();
    expAck.delete();
    check("reset_outputs",
          {bus.pm_we, bus.pm_addr, bus.pm_data, bus.tx_start, bus.tx_data,
           bus.cpu_run, bus.loading, bus.bad_op, bus.err_count}, 64'd0);
  endtask

  // Every memory write and acknowledge is matched against the model's queues.
  always @(negedge clk) begin
    if (bus.pm_we) begin
      wrCount++;
      if (expWr.size() == 0) begin
        check("unexpected_pm_we", {bus.pm_addr, bus.pm_data}, 64'hDEAD);
      end else begin
        check("pm_write", {bus.pm_addr, bus.pm_data}, expWr.pop_front());
      end
    end
    if (bus.tx_start) begin
      if (expAck.size() == 0) begin
        check("unexpected_tx_start", bus.tx_data, 64'hDEAD);
      end else begin
        check("tx_data", bus.tx_data, expAck.pop_front());
      end
    end
  end

  initial begin
    bit wd, lw;
    logic [7:0] b;
    int n;

    bus.rx_data      = 8'h00;
    bus.rx_done_tick = 1'b0;

    vecs[0] = '{6, 64'hA5021805_28030000, 2, 16'h2803, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{6, 64'h00FFA501_08100000, 1, 16'h0810, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{2, 64'hA5000000_00000000, 0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{4, 64'hA501F800_00000000, 1, 16'hF800, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{4, 64'hA50138FF_00000000, 1, 16'h38FF, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{4, 64'hA5014000_00000000, 1, 16'h4000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{6, 64'hA5020001_FFFF0000, 2, 16'hFFFF, 1'b1, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    doReset();

    // Table of complete frames, each from reset
    for (int v = 0; v < 7; v++) begin
      doReset();
      wrCount = 0;
      for (int k = 0; k < vecs[v].n; k++) begin
        b = vecs[v].bytes[63 - 8*k -: 8];
        sendByte(b);
      end
      check($sformatf("vec%0d_writes", v), wrCount, vecs[v].expWrites);
      check($sformatf("vec%0d_bad_op", v), bus.bad_op, vecs[v].expBadV);
      check($sformatf("vec%0d_err_count", v), bus.err_count, vecs[v].expErrV);
      check($sformatf("vec%0d_cpu_run", v), bus.cpu_run, vecs[v].expRunV);
      if (vecs[v].expWrites > 0) begin
        check($sformatf("vec%0d_pm_hold", v), {bus.pm_addr, bus.pm_data},
              {11'(vecs[v].expWrites - 1), vecs[v].expData});
      end
    end

    // Zero count, then a new sync clears err_count
    doReset();
    sendByte(8'hA5); sendByte(8'h00);
    check("zero_count_err", bus.err_count, 1'b1);
    sendByte(8'hA5);
    check("sync_clears_err", bus.err_count, 1'b0);
    sendByte(8'h01); sendByte(8'h11); sendByte(8'h22);

    // Bad opcode, then a reload clears bad_op and halts the CPU
    doReset();
    sendByte(8'hA5); sendByte(8'h01); sendByte(8'hF8); sendByte(8'h00);
    check("bad_op_set", bus.bad_op, 1'b1);
    check("run_after_bad", bus.cpu_run, 1'b1);
    sendByte(8'hA5);
    check("reload_clears_bad", bus.bad_op, 1'b0);
    check("reload_halts_cpu", bus.cpu_run, 1'b0);
    sendByte(8'h01); sendByte(8'h00); sendByte(8'h00);

    // Reset in the middle of a frame
    doReset();
    wrCount = 0;
    sendByte(8'hA5); sendByte(8'h03); sendByte(8'h11); sendByte(8'h22); sendByte(8'h33);
    doReset();
    repeat (10) @(negedge clk);
    check("abort_writes", wrCount, 1);
    check("abort_loading", bus.loading, 1'b0);

    // Bytes arriving during WRITE and DONE are dropped
    doReset();
    sendByte(8'hA5); sendByte(8'h01); sendByte(8'h08);
    modelByte(8'h10, wd, lw);
    @(negedge clk);
    bus.rx_data = 8'h10;
    bus.rx_done_tick = 1'b1;
    @(negedge clk);
    bus.rx_data = 8'hA5;
    check("drop_we", bus.pm_we, wd);
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    check("drop_tx_start", bus.tx_start, lw);
    @(negedge clk);
    checkFlags();
    check("drop_not_loading", bus.loading, 1'b0);
    check("drop_cpu_run", bus.cpu_run, 1'b1);

    // Maximum frame: 255 words
    doReset();
    wrCount = 0;
    sendByte(8'hA5); sendByte(8'hFF);
    for (int k = 0; k < 510; k++) sendByte(8'($urandom));
    repeat (4) @(negedge clk);
    check("max_writes", wrCount, 255);
    check("max_pm_addr", bus.pm_addr, 11'd254);
    check("max_cpu_run", bus.cpu_run, 1'b1);

    // Random frames with interleaved noise bytes
    doReset();
    for (int f = 0; f < 15; f++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        sendByte(b);
      end
      sendByte(8'hA5);
      n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
      sendByte(8'(n));
      for (int k = 0; k < 2*n; k++) sendByte(8'($urandom));
    end

    repeat (4) @(negedge clk);
    check("pending_writes", expWr.size(), 0);
    check("pending_acks", expAck.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
